// File: rtl/time_dmr_pkg.sv
// Shared ID helpers for the time-DMR stages: an ID is {^idx, idx}, so a well-formed
// ID always has even overall parity.
package time_dmr_pkg;

  localparam int unsigned DefaultIdSize = 3;

  typedef logic [DefaultIdSize-2:0] slot_idx_t;

  // Widened to 32 bits so one helper serves any IDSize; the caller slices the result.
  function automatic logic [31:0] encode_id(input logic [31:0] idx, input int unsigned id_size);
    logic [31:0] mask;
    logic [31:0] masked;
    mask   = (32'd1 << (id_size - 1)) - 32'd1;
    masked = idx & mask;
    return masked | ({31'd0, ^masked} << (id_size - 1));
  endfunction

  function automatic logic id_parity_ok(input logic [31:0] id);
    return ~^id;
  endfunction

endpackage

// File: rtl/time_dmr_retry_sel.sv
// Rotating lowest-set-bit finder: scans the vector upward from the given start index.
// Purely combinational, no backpressure.
module time_dmr_retry_sel #(
  parameter int unsigned IdxW = 2
) (
  input  logic [2**IdxW-1:0] pending,
  input  logic [IdxW-1:0]    oldest,
  output logic               found,
  output logic [IdxW-1:0]    idx
);

  localparam int unsigned N = 2 ** IdxW;

  logic [IdxW-1:0] probe;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    probe = '0;
    for (int i = 0; i < N; i++) begin
      probe = oldest + IdxW'(i);
      if (!found && pending[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/time_dmr_retry_ctrl.sv
// Retry scheduler ahead of the time-DMR start stage: tags elements with parity IDs, keeps a
// copy until the end stage reports, re-issues on mismatch. 1-cycle latency; ready_o drops when full, retrying or changing mode.
module time_dmr_retry_ctrl
  import time_dmr_pkg::*;
#(
  parameter type         DataType   = logic,
  parameter int unsigned IDSize     = 3,
  parameter int unsigned MaxRetries = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              result_valid_i,
  input  logic [IDSize-1:0] result_id_i,
  input  logic              result_fault_i,
  output logic              retry_o,
  output logic              fatal_o,
  output logic              id_error_o,
  output logic [IDSize-1:0] outstanding_o
);

  localparam int unsigned IdxW     = IDSize - 1;
  localparam int unsigned NumSlots = 2 ** IdxW;
  localparam int unsigned CntW     = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  logic [NumSlots-1:0] busy_q, pend_q;
  DataType             data_q [NumSlots];
  logic [CntW-1:0]     cnt_q  [NumSlots];
  logic [IdxW-1:0]     alloc_q;
  logic                mode_q;
  logic                out_valid_q, out_retry_q;
  DataType             out_data_q;
  logic [IDSize-1:0]   out_id_q;
  logic                fatal_q, id_error_q;

  logic            busy_found, retry_found;
  logic [IdxW-1:0] oldest_idx, retry_idx, res_idx;
  logic            can_load, retry_take, new_take;
  logic            res_act, res_bad, res_last, res_free, res_pend, res_fatal;
  logic [31:0]     new_id_w, rty_id_w;
  logic            unused_id_hi;

  // With round-robin allocation the oldest busy slot is the first busy one at or after alloc_q.
  time_dmr_retry_sel #(.IdxW(IdxW)) u_oldest (
    .pending (busy_q),
    .oldest  (alloc_q),
    .found   (busy_found),
    .idx     (oldest_idx)
  );

  time_dmr_retry_sel #(.IdxW(IdxW)) u_retry (
    .pending (pend_q),
    .oldest  (oldest_idx),
    .found   (retry_found),
    .idx     (retry_idx)
  );

  assign can_load   = !out_valid_q || ready_i;
  assign retry_take = can_load && retry_found;
  assign ready_o    = can_load && !retry_found && !busy_q[alloc_q] && (mode_q == enable_i);
  assign new_take   = valid_i && ready_o;

  assign new_id_w     = encode_id(32'(alloc_q), IDSize);
  assign rty_id_w     = encode_id(32'(retry_idx), IDSize);
  assign unused_id_hi = ^{new_id_w, rty_id_w};

  // Results only matter while redundancy is active; in bypass they are dropped silently.
  assign res_idx   = result_id_i[IdxW-1:0];
  assign res_act   = result_valid_i && mode_q;
  assign res_bad   = res_act && (!id_parity_ok(32'(result_id_i)) || !busy_q[res_idx] || pend_q[res_idx]);
  assign res_last  = (cnt_q[res_idx] == CntW'(MaxRetries));
  assign res_free  = res_act && !res_bad && (!result_fault_i || res_last);
  assign res_pend  = res_act && !res_bad && result_fault_i && !res_last;
  assign res_fatal = res_act && !res_bad && result_fault_i && res_last;

  assign valid_o    = out_valid_q;
  assign data_o     = out_data_q;
  assign id_o       = out_id_q;
  assign retry_o    = out_valid_q && ready_i && out_retry_q;
  assign fatal_o    = fatal_q;
  assign id_error_o = id_error_q;

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      outstanding_o = outstanding_o + {{(IDSize-1){1'b0}}, busy_q[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      pend_q      <= '0;
      alloc_q     <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_retry_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      fatal_q     <= 1'b0;
      id_error_q  <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      fatal_q    <= res_fatal;
      id_error_q <= res_bad;

      if (!out_valid_q && !busy_found) begin
        mode_q <= enable_i;
      end

      if (can_load) begin
        out_valid_q <= retry_take || new_take;
        out_retry_q <= retry_take;
        if (retry_take) begin
          out_data_q <= data_q[retry_idx];
          out_id_q   <= rty_id_w[IDSize-1:0];
        end else if (new_take) begin
          out_data_q <= data_i;
          out_id_q   <= new_id_w[IDSize-1:0];
        end
      end

      if (retry_take) begin
        pend_q[retry_idx] <= 1'b0;
        cnt_q[retry_idx]  <= cnt_q[retry_idx] + CntW'(1);
      end

      if (new_take) begin
        alloc_q <= alloc_q + IdxW'(1);
        if (mode_q) begin
          busy_q[alloc_q] <= 1'b1;
          data_q[alloc_q] <= data_i;
          cnt_q[alloc_q]  <= '0;
        end
      end

      // Never the same slot as the allocation or retry above: those need a free / pending slot.
      if (res_free) begin
        busy_q[res_idx] <= 1'b0;
      end
      if (res_pend) begin
        pend_q[res_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_dmr_retry_ctrl.sv
// Bench for time_dmr_retry_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against an age-ordered slot model.
module tb_time_dmr_retry_ctrl;

  localparam int IDS = 3;
  localparam int NS  = 4;
  localparam int MR  = 2;

  typedef logic [7:0] data_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b1;
  data_t      data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  data_t      data_o;
  logic [2:0] id_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       result_valid_i = 1'b0;
  logic [2:0] result_id_i = '0;
  logic       result_fault_i = 1'b0;
  logic       retry_o, fatal_o, id_error_o;
  logic [2:0] outstanding_o;

  time_dmr_retry_ctrl #(.DataType(data_t), .IDSize(IDS), .MaxRetries(MR)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .id_o           (id_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_valid_i (result_valid_i),
    .result_id_i    (result_id_i),
    .result_fault_i (result_fault_i),
    .retry_o        (retry_o),
    .fatal_o        (fatal_o),
    .id_error_o     (id_error_o),
    .outstanding_o  (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: slot table plus allocation sequence numbers, which define age.
  bit    m_busy [NS];
  bit    m_pend [NS];
  data_t m_data [NS];
  int    m_tries[NS];
  int    m_seq  [NS];
  int    seq_ctr;
  int    m_alloc;
  bit    m_mode;
  bit    m_ov, m_oretry;
  data_t m_od;
  int    m_oid;
  bit    m_fatal, m_iderr;

  function automatic int enc(int idx);
    return idx | (($countones(idx) % 2) << (IDS - 1));
  endfunction

  function automatic int oldest_pend();
    int best = -1;
    for (int i = 0; i < NS; i++)
      if (m_pend[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    return best;
  endfunction

  function automatic int busy_cnt();
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit exp_ready();
    return (!m_ov || ready_i) && (oldest_pend() < 0) && !m_busy[m_alloc] && (m_mode == enable_i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_busy[i] = 0; m_pend[i] = 0; m_data[i] = '0; m_tries[i] = 0; m_seq[i] = 0;
    end
    seq_ctr = 0; m_alloc = 0; m_mode = 0; m_ov = 0; m_oretry = 0; m_od = '0; m_oid = 0;
    m_fatal = 0; m_iderr = 0;
  endtask

  task automatic model_step();
    int  p, ri;
    bit  cl, rdy, mode_ok, fat_n, ide_n;
    cl      = !m_ov || ready_i;
    p       = oldest_pend();
    rdy     = exp_ready();
    mode_ok = !m_ov && (busy_cnt() == 0);
    fat_n   = 0;
    ide_n   = 0;
    if (m_mode && result_valid_i) begin
      ri = int'(result_id_i) % NS;
      if (($countones(result_id_i) % 2) != 0 || !m_busy[ri] || m_pend[ri]) ide_n = 1;
      else if (!result_fault_i) m_busy[ri] = 0;
      else if (m_tries[ri] < MR) m_pend[ri] = 1;
      else begin
        m_busy[ri] = 0;
        fat_n = 1;
      end
    end
    if (cl) begin
      if (p >= 0) begin
        m_ov = 1; m_oretry = 1; m_od = m_data[p]; m_oid = enc(p);
        m_pend[p] = 0; m_tries[p]++;
      end else if (valid_i && rdy) begin
        m_ov = 1; m_oretry = 0; m_od = data_i; m_oid = enc(m_alloc);
        if (m_mode) begin
          m_busy[m_alloc] = 1; m_data[m_alloc] = data_i; m_tries[m_alloc] = 0;
          m_seq[m_alloc] = seq_ctr++;
        end
        m_alloc = (m_alloc + 1) % NS;
      end else begin
        m_ov = 0;
      end
    end
    if (mode_ok) m_mode = enable_i;
    m_fatal = fat_n;
    m_iderr = ide_n;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("valid_o", 32'(valid_o), 32'(m_ov));
    if (m_ov) begin
      chk("data_o", 32'(data_o), 32'(m_od));
      chk("id_o", 32'(id_o), m_oid);
    end
    chk("ready_o", 32'(ready_o), 32'(exp_ready()));
    chk("retry_o", 32'(retry_o), 32'(m_ov && ready_i && m_oretry));
    chk("fatal_o", 32'(fatal_o), 32'(m_fatal));
    chk("id_error_o", 32'(id_error_o), 32'(m_iderr));
    chk("outstanding_o", 32'(outstanding_o), busy_cnt());
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_in(input bit v, input data_t d, input bit rv, input logic [2:0] rid, input bit rf);
    valid_i = v; data_i = d; result_valid_i = rv; result_id_i = rid; result_fault_i = rf;
  endtask

  // Called at a negedge.
  task automatic do_reset();
    rst_ni = 1'b0;
    set_in(0, '0, 0, '0, 0);
    enable_i = 1'b1;
    model_reset();
    #1;
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_ready_o", 32'(ready_o), 0);
    chk("rst_retry_o", 32'(retry_o), 0);
    chk("rst_fatal_o", 32'(fatal_o), 0);
    chk("rst_id_error_o", 32'(id_error_o), 0);
    chk("rst_outstanding_o", 32'(outstanding_o), 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic random_cycle();
    int s, pick, c;
    valid_i = ($urandom_range(0, 9) < 6);
    data_i  = data_t'($urandom);
    ready_i = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 199) == 0) enable_i = ~enable_i;
    result_valid_i = ($urandom_range(0, 3) == 0);
    result_fault_i = ($urandom_range(0, 9) < 4);
    s = $urandom_range(0, NS - 1);
    pick = -1;
    for (int j = 0; j < NS; j++) begin
      c = (s + j) % NS;
      if (pick < 0 && m_busy[c] && !m_pend[c]) pick = c;
    end
    if (pick >= 0 && $urandom_range(0, 9) < 8) result_id_i = 3'(enc(pick));
    else result_id_i = 3'($urandom);
    tick();
  endtask

  int ids1[3] = '{0, 5, 6};
  int ids3[4] = '{6, 3, 0, 5};

  initial begin
    @(negedge clk_i);
    do_reset();

    // Mode is adopted one cycle after reset; until then nothing is accepted.
    set_in(0, '0, 0, '0, 0);
    #1 chk("ready_mode_wait", 32'(ready_o), 0);
    tick();

    for (int k = 0; k < 3; k++) begin
      set_in(1, data_t'(8'hA0 + k), 0, '0, 0);
      tick();
      chk("abc_id", 32'(id_o), ids1[k]);
      chk("abc_outstanding", 32'(outstanding_o), k + 1);
    end
    set_in(0, '0, 0, '0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, '0, 1, 3'(ids1[k]), 0);
      tick();
    end
    chk("clean_outstanding", 32'(outstanding_o), 0);

    // Faults on one element: two re-issues, then fatal.
    set_in(1, 8'h31, 0, '0, 0); tick();
    chk("d1_id", 32'(id_o), 3);
    set_in(1, 8'h32, 0, '0, 0); tick();
    chk("d2_id", 32'(id_o), 0);
    chk("d2_outstanding", 32'(outstanding_o), 2);
    set_in(0, '0, 1, 3'h0, 1); tick();
    set_in(1, 8'h33, 0, '0, 0);
    #1 chk("ready_blocked_by_retry", 32'(ready_o), 0);
    tick();
    chk("reissue_id", 32'(id_o), 0);
    chk("reissue_data", 32'(data_o), 32'h32);
    #1 chk("reissue_retry_pulse", 32'(retry_o), 1);
    chk("ready_after_reissue", 32'(ready_o), 1);
    tick();
    chk("d3_id", 32'(id_o), 5);
    chk("d3_data", 32'(data_o), 32'h33);
    set_in(0, '0, 1, 3'h0, 1); tick();
    set_in(0, '0, 0, '0, 0); tick();
    chk("reissue2_id", 32'(id_o), 0);
    set_in(0, '0, 1, 3'h0, 1); tick();
    chk("fatal_pulse", 32'(fatal_o), 1);
    chk("fatal_outstanding", 32'(outstanding_o), 2);
    set_in(0, '0, 1, 3'h3, 0); tick();
    set_in(0, '0, 1, 3'h5, 0); tick();
    set_in(0, '0, 0, '0, 0); tick();
    chk("fatal_drain_outstanding", 32'(outstanding_o), 0);

    // Fill all four slots, then free out of order.
    for (int k = 0; k < 4; k++) begin
      set_in(1, data_t'(8'h40 + k), 0, '0, 0);
      tick();
      chk("fill_id", 32'(id_o), ids3[k]);
    end
    chk("full_outstanding", 32'(outstanding_o), 4);
    set_in(1, 8'h44, 0, '0, 0);
    #1 chk("ready_full", 32'(ready_o), 0);
    set_in(1, 8'h44, 1, 3'h0, 0); tick();
    set_in(1, 8'h44, 0, '0, 0);
    #1 chk("ready_full_ooo_free", 32'(ready_o), 0);
    tick();
    set_in(1, 8'h44, 1, 3'h6, 0); tick();
    set_in(1, 8'h44, 0, '0, 0);
    #1 chk("ready_after_free", 32'(ready_o), 1);
    tick();
    chk("wrap_id", 32'(id_o), 6);
    chk("wrap_data", 32'(data_o), 32'h44);

    // Bad parity and free-slot reports.
    set_in(0, '0, 1, 3'h1, 0); tick();
    chk("bad_parity_err", 32'(id_error_o), 1);
    chk("bad_parity_outstanding", 32'(outstanding_o), 3);
    set_in(0, '0, 1, 3'h0, 1); tick();
    chk("free_slot_err", 32'(id_error_o), 1);
    chk("free_slot_fatal", 32'(fatal_o), 0);

    // Switch to bypass with elements outstanding.
    enable_i = 1'b0;
    set_in(1, 8'h66, 0, '0, 0);
    #1 chk("ready_mode_change", 32'(ready_o), 0);
    for (int i = 0; i < NS; i++) begin
      if (m_busy[i]) begin
        set_in(1, 8'h66, 1, 3'(enc(i)), 0);
        tick();
      end
    end
    set_in(0, '0, 0, '0, 0); tick();
    set_in(1, 8'h66, 0, '0, 0);
    #1 chk("ready_bypass", 32'(ready_o), 1);
    tick();
    set_in(0, '0, 1, 3'h1, 1); tick();
    set_in(0, '0, 1, 3'h3, 1); tick();
    chk("bypass_no_err", 32'(id_error_o), 0);
    chk("bypass_no_fatal", 32'(fatal_o), 0);
    chk("bypass_outstanding", 32'(outstanding_o), 0);

    enable_i = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset();
      random_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
